// File: rtl/crossover_engine.sv
// Two-stage genetic-algorithm crossover unit: S1 latches the parents and effective mask, S2 forms the children.
// An 8-bit LFSR compared against xover_prob decides whether each accepted pair is actually recombined.
module crossover_engine #(
    parameter int unsigned CHROM_WIDTH = 8,
    parameter int unsigned PT_WIDTH    = $clog2(CHROM_WIDTH) + 1,
    parameter logic [7:0]  LFSR_SEED   = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHROM_WIDTH-1:0] parent1,
    input  logic [CHROM_WIDTH-1:0] parent2,
    input  logic [1:0]             mode,
    input  logic [PT_WIDTH-1:0]    point_a,
    input  logic [PT_WIDTH-1:0]    point_b,
    input  logic [CHROM_WIDTH-1:0] mask,
    input  logic [7:0]             xover_prob,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHROM_WIDTH-1:0] child1,
    output logic [CHROM_WIDTH-1:0] child2,
    output logic                   crossed,
    output logic [15:0]            cross_count
);

    localparam int unsigned CW = CHROM_WIDTH;
    localparam int unsigned PW = PT_WIDTH;

    typedef enum logic [1:0] {
        MODE_SINGLE  = 2'd0,
        MODE_TWO     = 2'd1,
        MODE_UNIFORM = 2'd2,
        MODE_COPY    = 2'd3
    } mode_e;

    logic          s1_valid_q, s1_valid_d;
    logic [CW-1:0] s1_p1_q, s1_p1_d;
    logic [CW-1:0] s1_p2_q, s1_p2_d;
    logic [CW-1:0] s1_m_q, s1_m_d;
    logic          s1_x_q, s1_x_d;
    logic          s2_valid_q, s2_valid_d;
    logic [CW-1:0] child1_q, child1_d;
    logic [CW-1:0] child2_q, child2_d;
    logic          crossed_q, crossed_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    lfsr_q, lfsr_d;

    logic          advance_c;
    logic          accept_c;
    logic          gate_c;
    logic          lfsr_fb_c;
    logic [PW-1:0] lo_c, hi_c;
    logic [CW-1:0] raw_mask_c;
    logic [CW-1:0] eff_mask_c;

    // Mask generation: bit i set means child1 takes parent1 at that position.
    always_comb begin
        lo_c       = point_a;
        hi_c       = point_b;
        raw_mask_c = '1;
        if (point_b < point_a) begin
            lo_c = point_b;
            hi_c = point_a;
        end
        for (int unsigned i = 0; i < CW; i++) begin
            case (mode_e'(mode))
                MODE_SINGLE:  raw_mask_c[i] = (32'(i) >= 32'(point_a));
                MODE_TWO:     raw_mask_c[i] = !((32'(i) >= 32'(lo_c)) && (32'(i) < 32'(hi_c)));
                MODE_UNIFORM: raw_mask_c[i] = mask[i];
                default:      raw_mask_c[i] = 1'b1;
            endcase
        end
        gate_c     = (lfsr_q <= xover_prob) && (mode_e'(mode) != MODE_COPY);
        eff_mask_c = gate_c ? raw_mask_c : '1;
    end

    // Pipeline advance, LFSR step and count update.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p1_d    = s1_p1_q;
        s1_p2_d    = s1_p2_q;
        s1_m_d     = s1_m_q;
        s1_x_d     = s1_x_q;
        s2_valid_d = s2_valid_q;
        child1_d   = child1_q;
        child2_d   = child2_q;
        crossed_d  = crossed_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;

        advance_c = !s2_valid_q || out_ready;
        accept_c  = in_valid && advance_c;
        // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
        lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

        if (accept_c) begin
            lfsr_d  = {lfsr_q[6:0], lfsr_fb_c};
            s1_p1_d = parent1;
            s1_p2_d = parent2;
            s1_m_d  = eff_mask_c;
            s1_x_d  = gate_c;
        end

        if (advance_c) begin
            s1_valid_d = accept_c;
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                child1_d  = (s1_p1_q & s1_m_q) | (s1_p2_q & ~s1_m_q);
                child2_d  = (s1_p2_q & s1_m_q) | (s1_p1_q & ~s1_m_q);
                crossed_d = s1_x_q;
            end
        end

        if (s2_valid_q && out_ready && crossed_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p1_q    <= '0;
            s1_p2_q    <= '0;
            s1_m_q     <= '0;
            s1_x_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            child1_q   <= '0;
            child2_q   <= '0;
            crossed_q  <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p1_q    <= s1_p1_d;
            s1_p2_q    <= s1_p2_d;
            s1_m_q     <= s1_m_d;
            s1_x_q     <= s1_x_d;
            s2_valid_q <= s2_valid_d;
            child1_q   <= child1_d;
            child2_q   <= child2_d;
            crossed_q  <= crossed_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign in_ready    = advance_c;
    assign out_valid   = s2_valid_q;
    assign child1      = child1_q;
    assign child2      = child2_q;
    assign crossed     = crossed_q;
    assign cross_count = cnt_q;

endmodule

// File: doc/crossover_engine.md
CROSSOVER_ENGINE -- requirements
Module: crossover_engine

Interface
REQ-001 The block SHALL have parameter CHROM_WIDTH, default 8, giving the chromosome width in bits; legal range is 4 to 64.
REQ-002 The block SHALL have parameter PT_WIDTH, default $clog2(CHROM_WIDTH)+1, giving the crossover-point width.
REQ-003 The block SHALL have parameter LFSR_SEED, default 8'h01, giving the non-zero LFSR reset value.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: a parent pair is presented.
REQ-007 Port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-008 Port parent1 and parent2, input, CHROM_WIDTH bits each: the parent chromosomes.
REQ-009 Port mode, input, 2 bits: 0 = single-point, 1 = two-point, 2 = uniform, 3 = copy.
REQ-010 Port point_a and point_b, input, PT_WIDTH bits each: the crossover points.
REQ-011 Port mask, input, CHROM_WIDTH bits: the uniform-mode selection mask.
REQ-012 Port xover_prob, input, 8 bits: the crossover probability threshold.
REQ-013 Port out_valid, output, 1 bit: a child pair is presented.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the child pair.
REQ-015 Port child1 and child2, output, CHROM_WIDTH bits each: the offspring.
REQ-016 Port crossed, output, 1 bit: the presented pair was actually recombined.
REQ-017 Port cross_count, output, 16 bits: the number of recombined pairs delivered.

Function
REQ-018 Inputs SHALL be sampled on the cycle where in_valid && in_ready (the accept cycle); input values are don't-care on all other cycles.
REQ-019 The block SHALL be a 2-stage pipeline: S1 registers the parents and the effective mask, S2 registers the children.
- Latency: accept at cycle N gives out_valid at N+2 when there is no stall.
REQ-020 Global stall rule: advance = !s2_valid || out_ready, and in_ready = advance.
- When advance is low, both stages SHALL hold and child1, child2, crossed and out_valid SHALL stay stable.
REQ-021 Bubbles SHALL propagate: S1 valid loads in_valid && in_ready, and s2_valid loads s1_valid whenever advance is high.
REQ-022 Mask M, where bit i = 1 selects parent1 for child1, SHALL be built as follows:
- Mode 0: M[i] = (i >= point_a).
- Mode 1: with lo = min(point_a, point_b) and hi = max(point_a, point_b), M[i] = !(lo <= i < hi).
- Mode 2: M = mask.
- Mode 3: M = all ones.
REQ-023 Point boundary values SHALL behave as follows:
- point_a = 0 in mode 0 gives M = all ones.
- point_a >= CHROM_WIDTH in mode 0 gives M = all zeros (full swap).
- point_a == point_b in mode 1 gives M = all ones.
- hi >= CHROM_WIDTH in mode 1 swaps bits lo through CHROM_WIDTH-1.
REQ-024 The block SHALL contain an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
- It steps exactly once per accept cycle and never steps otherwise.
REQ-025 Gate: on an accept, the crossover SHALL pass when the current (pre-step) LFSR value <= xover_prob and mode != 3.
- On a failed gate, M SHALL be forced to all ones.
- Consequence: xover_prob = 255 always passes, and xover_prob = 0 never passes, since the LFSR is never 0.
REQ-026 Children SHALL be computed in S2 as:
- child1 = (parent1 & M) | (parent2 & ~M)
- child2 = (parent2 & M) | (parent1 & ~M)
REQ-027 crossed SHALL equal the gate result carried alongside the pair through the pipeline.
REQ-028 cross_count SHALL increment by 1 on each output handshake (out_valid && out_ready) where crossed = 1, and saturate at 16'hFFFF.
REQ-029 With mode 0 and point_a = CHROM_WIDTH/2, the behaviour SHALL equal the fixed half-split recombination of the previous generation.

Reset
REQ-030 While rst = 1 at a clock edge, the block SHALL clear S1 valid and s2_valid and set:
- out_valid = 0, child1 = 0, child2 = 0, crossed = 0;
- cross_count = 0, LFSR = LFSR_SEED.
- in_ready SHALL read 1 from the cycle after reset releases.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight pairs with no output handshake, and no pair accepted before reset SHALL ever appear at the outputs.

Verification
REQ-032 Single-point: CHROM_WIDTH=8, xover_prob=255, mode 0, point_a=4, parent1=0xF0, parent2=0x0F -> at N+2 child1=0xFF, child2=0x00, crossed=1, cross_count=1 after the handshake.
REQ-033 Two-point and uniform: mode 1, point_a=6, point_b=2, parent1=0xFF, parent2=0x00 -> child1=0xC3, child2=0x3C; then mode 2, mask=0xAA -> child1=0xAA, child2=0x55.
REQ-034 Gate off: xover_prob=0, mode 0, point_a=3, parent1=0x5A, parent2=0xA5 -> child1=0x5A, child2=0xA5, crossed=0, cross_count unchanged.
REQ-035 Backpressure: out_ready=0 while 3 back-to-back pairs are offered -> 2 pairs accepted, in_ready=0 from the 3rd cycle, outputs stable; on out_ready=1, the pairs emerge in order with no loss or duplication.
REQ-036 Boundaries: mode 0 with point_a=8 -> children fully swapped; mode 1 with point_a=point_b=5 -> children equal the parents, crossed=1.
REQ-037 Reset mid-flight: accept 2 pairs, assert rst for 1 cycle -> out_valid=0, cross_count=0, and neither pair is ever output.
